// File: rtl/afe_spi_ctrl.sv
// Command-driven SPI master (mode 0) for the AFE link: shifts 1-32 bits MSB-first,
// pulses the spi_sel latch strobe, then returns the captured MISO word.
module afe_spi_ctrl #(
  parameter int CLK_DIV   = 4,
  parameter int LATCH_CYC = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  input  logic [4:0]  cmd_len,
  input  logic [1:0]  cmd_csel,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        spi_clk_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic        spi_sel,
  output logic        sel0,
  output logic        sel1
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, LATCH, DONE} state_t;

  localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);
  localparam logic [7:0] LAT_LD = 8'(LATCH_CYC - 1);

  state_t      r_state;
  logic [7:0]  r_div;
  logic [5:0]  r_bits;
  logic [5:0]  r_len;
  logic [31:0] r_sh;
  logic [31:0] r_rx;
  logic        r_s1, r_s2;

  logic [5:0]  w_len;
  logic [5:0]  w_shift;

  // cmd_len of 0 encodes a full 32-bit transfer
  assign w_len      = (cmd_len == 5'd0) ? 6'd32 : {1'b0, cmd_len};
  assign w_shift    = 6'd32 - w_len;
  assign spi_mosi_o = r_sh[31];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= IDLE;
      r_div     <= 8'd0;
      r_bits    <= 6'd0;
      r_len     <= 6'd0;
      r_sh      <= 32'd0;
      r_rx      <= 32'd0;
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      busy      <= 1'b0;
      spi_clk_o <= 1'b0;
      spi_sel   <= 1'b0;
      sel0      <= 1'b0;
      sel1      <= 1'b0;
    end else begin
      r_s1 <= spi_miso_i;
      r_s2 <= r_s1;
      case (r_state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            r_len       <= w_len;
            {sel1, sel0} <= cmd_csel;
            // left-align so bit (N-1) sits on MOSI; zeros behind it idle MOSI low at the end
            r_sh        <= cmd_data << w_shift;
            r_rx        <= 32'd0;
            r_bits      <= 6'd0;
            busy        <= 1'b1;
            cmd_ready   <= 1'b0;
            r_div       <= DIV_LD;
            r_state     <= SETUP;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          if (r_div == 8'd0) begin
            r_div     <= DIV_LD;
            spi_clk_o <= 1'b1;
            r_state   <= HIGH;
          end else begin
            r_div <= r_div - 8'd1;
          end
        end
        HIGH: begin
          if (r_div == 8'd0) begin
            r_rx      <= {r_rx[30:0], r_s2};
            r_bits    <= r_bits + 6'd1;
            r_sh      <= {r_sh[30:0], 1'b0};
            spi_clk_o <= 1'b0;
            r_div     <= DIV_LD;
            r_state   <= LOW;
          end else begin
            r_div <= r_div - 8'd1;
          end
        end
        LOW: begin
          if (r_div == 8'd0) begin
            if (r_bits < r_len) begin
              spi_clk_o <= 1'b1;
              r_div     <= DIV_LD;
              r_state   <= HIGH;
            end else begin
              spi_sel <= 1'b1;
              r_div   <= LAT_LD;
              r_state <= LATCH;
            end
          end else begin
            r_div <= r_div - 8'd1;
          end
        end
        LATCH: begin
          if (r_div == 8'd0) begin
            spi_sel <= 1'b0;
            r_state <= DONE;
          end else begin
            r_div <= r_div - 8'd1;
          end
        end
        DONE: begin
          rsp_valid <= 1'b1;
          rsp_data  <= r_rx;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afe_spi_ctrl.sv
// Bench for afe_spi_ctrl: table of commands with hand-derived timing, a response
// scoreboard queue, plus busy-rejection, mid-transfer reset and fast-divider sequences.
module tb_afe_spi_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        c_valid, c_ready, r_valid, busy, sclk, mosi, miso, ssel, s0, s1;
  logic [31:0] c_data, r_data;
  logic [4:0]  c_len;
  logic [1:0]  c_csel, miso_mode;

  // mode 2 loops MOSI back, otherwise MISO is tied to mode[0]
  assign miso = (miso_mode == 2'd2) ? mosi : miso_mode[0];

  afe_spi_ctrl #(.CLK_DIV(4), .LATCH_CYC(4)) dut (
    .sys_clk(clk), .sys_rst(rst), .cmd_valid(c_valid), .cmd_ready(c_ready),
    .cmd_data(c_data), .cmd_len(c_len), .cmd_csel(c_csel), .rsp_valid(r_valid),
    .rsp_data(r_data), .busy(busy), .spi_clk_o(sclk), .spi_mosi_o(mosi),
    .spi_miso_i(miso), .spi_sel(ssel), .sel0(s0), .sel1(s1));

  logic        c_valid_d, c_ready_d, r_valid_d, busy_d, sclk_d, mosi_d, miso_d, ssel_d, s0_d, s1_d;
  logic [31:0] c_data_d, r_data_d;
  logic [4:0]  c_len_d;
  logic [1:0]  c_csel_d;

  afe_spi_ctrl #(.CLK_DIV(1), .LATCH_CYC(1)) dut_fast (
    .sys_clk(clk), .sys_rst(rst), .cmd_valid(c_valid_d), .cmd_ready(c_ready_d),
    .cmd_data(c_data_d), .cmd_len(c_len_d), .cmd_csel(c_csel_d), .rsp_valid(r_valid_d),
    .rsp_data(r_data_d), .busy(busy_d), .spi_clk_o(sclk_d), .spi_mosi_o(mosi_d),
    .spi_miso_i(miso_d), .spi_sel(ssel_d), .sel0(s0_d), .sel1(s1_d));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name, input logic [31:0] act);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected response %0h, scoreboard empty", name, act);
    end else begin
      chk(name, act, sb_q.pop_front());
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [4:0]  len;
    logic [1:0]  csel;
    logic [1:0]  mode;
    logic [31:0] exp_rsp;
    logic [31:0] exp_mosi;
    int          exp_edges;
    int          exp_sel;
    int          exp_rv;
  } vec_t;

  vec_t vecs[6];

  task automatic run_cmd(input vec_t v, input bit reject);
    int          edges = 0, sel_first = -1, sel_cnt = 0, rv_cyc = -1, rv_cnt = 0;
    logic [31:0] mosi_w = 32'd0;
    logic        prev = 1'b0;
    bit          early_ready = 0, early_idle = 0;
    @(negedge clk);
    chk("ready_before", c_ready, 1);
    miso_mode = v.mode; c_data = v.data; c_len = v.len; c_csel = v.csel; c_valid = 1'b1;
    sb_q.push_back(v.exp_rsp);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (k == 0) c_valid = 1'b0;
      if (reject && k == 4) begin c_valid = 1'b1; c_data = ~v.data; end
      if (reject && k == 8) c_valid = 1'b0;
      if (k == 1) chk("sel_pins", {s1, s0}, v.csel);
      if (sclk && !prev) begin edges++; mosi_w = {mosi_w[30:0], mosi}; end
      prev = sclk;
      if (ssel) begin if (sel_first < 0) sel_first = k; sel_cnt++; end
      if (rv_cyc < 0 && !r_valid) begin
        if (c_ready) early_ready = 1;
        if (!busy) early_idle = 1;
      end
      if (r_valid) begin
        rv_cnt++;
        if (rv_cyc < 0) begin rv_cyc = k; pop_chk("rsp_data", r_data); end
      end
      if (rv_cyc >= 0 && k == rv_cyc + 1) chk("ready_after", c_ready, 1);
      if (rv_cyc >= 0 && k == rv_cyc + 4) break;
    end
    chk("sclk_edges", edges, v.exp_edges);
    chk("mosi_bits", mosi_w, v.exp_mosi);
    chk("sel_rise", sel_first, v.exp_sel);
    chk("sel_width", sel_cnt, 4);
    chk("rsp_cycle", rv_cyc, v.exp_rv);
    chk("rsp_count", rv_cnt, 1);
    chk("ready_while_busy", early_ready, 0);
    chk("busy_dropped_early", early_idle, 0);
  endtask

  initial begin
    int edges, rv_cnt, rv_cyc, r0, r1;
    c_valid = 0; c_data = 0; c_len = 0; c_csel = 0; miso_mode = 0;
    c_valid_d = 0; c_data_d = 0; c_len_d = 0; c_csel_d = 0; miso_d = 1'b1;

    vecs[0] = '{32'h0000_00A5, 5'd8,  2'd2, 2'd2, 32'h0000_00A5, 32'h0000_00A5, 8,  68,  73};
    vecs[1] = '{32'h8000_0001, 5'd0,  2'd1, 2'd1, 32'hFFFF_FFFF, 32'h8000_0001, 32, 260, 265};
    vecs[2] = '{32'h0000_0001, 5'd1,  2'd3, 2'd0, 32'h0000_0000, 32'h0000_0001, 1,  12,  17};
    vecs[3] = '{32'h0001_2345, 5'd20, 2'd0, 2'd2, 32'h0001_2345, 32'h0001_2345, 20, 164, 169};
    vecs[4] = '{32'hFFFF_0F0F, 5'd12, 2'd1, 2'd2, 32'h0000_0F0F, 32'h0000_0F0F, 12, 100, 105};
    vecs[5] = '{32'hDEAD_BEEF, 5'd0,  2'd2, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32, 260, 265};

    #12;
    chk("rst_ready", c_ready, 1);
    chk("rst_outs", {r_valid, busy, sclk, mosi, ssel, s1, s0}, 0);
    chk("rst_rsp_data", r_data, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 6; i++) run_cmd(vecs[i], 0);

    // second request during an active transfer must be dropped
    run_cmd(vecs[0], 1);

    // reset in the middle of bit 4, no clock edge before the check
    @(negedge clk);
    miso_mode = 2'd2; c_data = 32'hA5; c_len = 5'd8; c_csel = 2'd1; c_valid = 1'b1;
    edges = 0;
    begin
      logic prev = 1'b0;
      for (int k = 0; k < 300 && edges < 4; k++) begin
        @(negedge clk);
        c_valid = 1'b0;
        if (sclk && !prev) edges++;
        prev = sclk;
      end
    end
    chk("abort_reached_bit4", edges, 4);
    rst = 1'b1;
    #1;
    chk("abort_ready", c_ready, 1);
    chk("abort_outs", {r_valid, busy, sclk, mosi, ssel, s1, s0}, 0);
    chk("abort_rsp_data", r_data, 0);
    @(negedge clk); rst = 1'b0;
    rv_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (r_valid) rv_cnt++;
    end
    chk("abort_no_rsp", rv_cnt, 0);
    run_cmd(vecs[3], 0);

    // fastest divider: SCLK period of two cycles
    @(negedge clk);
    c_data_d = 32'h5; c_len_d = 5'd4; c_csel_d = 2'd1; c_valid_d = 1'b1;
    sb_q.push_back(32'h0000_000F);
    edges = 0; rv_cyc = -1; r0 = -1; r1 = -1;
    begin
      logic prev = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (k == 0) c_valid_d = 1'b0;
        if (sclk_d && !prev) begin
          if (edges == 0) r0 = k;
          if (edges == 1) r1 = k;
          edges++;
        end
        prev = sclk_d;
        if (r_valid_d && rv_cyc < 0) begin rv_cyc = k; pop_chk("fast_rsp_data", r_data_d); end
        if (rv_cyc >= 0 && k == rv_cyc + 2) break;
      end
    end
    chk("fast_edges", edges, 4);
    chk("fast_period", r1 - r0, 2);
    chk("fast_rsp_cycle", rv_cyc, 11);
    chk("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
